// File: rtl/clock_down_multi.sv
// N-channel programmable clock divider with glitch-free, period-boundary-aligned divisor and enable updates.
// Optional realign input i_sync is compiled in when CLK_DOWN_SYNC_EN is defined.
module clock_down_multi #(
    parameter int NCH   = 2,
    parameter int DIV_W = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NCH*DIV_W-1:0] i_divisor,
    input  logic [NCH-1:0]       i_en,
`ifdef CLK_DOWN_SYNC_EN
    input  logic                 i_sync,
`endif
    output logic [NCH-1:0]       o_slow_clk,
    output logic [NCH-1:0]       o_tick,
    output logic [NCH-1:0]       o_active
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        state_t           r_state;
        state_t           w_state_nxt;
        logic [DIV_W-1:0] r_count;
        logic [DIV_W-1:0] r_div_act;
        logic             r_out;
        logic             r_tick;
        logic             r_active;
        logic [DIV_W-1:0] w_count_nxt;
        logic [DIV_W-1:0] w_div_nxt;
        logic             w_out_nxt;
        logic             w_active_nxt;
        logic [DIV_W-1:0] w_div_in;
        logic             w_div_ok;
        logic [DIV_W-1:0] w_lo_new;
        logic [DIV_W-1:0] w_lo_act;
        logic             w_wrap;
        logic [DIV_W-1:0] w_count_inc;

        assign w_div_in    = i_divisor[k*DIV_W +: DIV_W];
        assign w_div_ok    = (w_div_in > ONE);
        // ceil(div/2) without a DIV_W+1 wide sum, so the full divisor range is safe
        assign w_lo_new    = (w_div_in >> 1) + {{(DIV_W-1){1'b0}}, w_div_in[0]};
        assign w_lo_act    = (r_div_act >> 1) + {{(DIV_W-1){1'b0}}, r_div_act[0]};
        assign w_wrap      = (r_count == (r_div_act - ONE));
        assign w_count_inc = w_wrap ? '0 : (r_count + ONE);

        always_comb begin
            w_state_nxt  = r_state;
            w_count_nxt  = r_count;
            w_div_nxt    = r_div_act;
            w_out_nxt    = r_out;
            w_active_nxt = r_active;
            case (r_state)
                IDLE: begin
                    w_count_nxt  = '0;
                    w_div_nxt    = '0;
                    w_out_nxt    = 1'b0;
                    w_active_nxt = 1'b0;
                    if (i_en[k] && w_div_ok) begin
                        // The start edge already counts as the first edge of the period.
                        w_state_nxt  = RUN;
                        w_div_nxt    = w_div_in;
                        w_count_nxt  = ONE;
                        w_out_nxt    = (w_lo_new <= ONE);
                        w_active_nxt = 1'b1;
                    end
                end
                RUN: begin
                    w_count_nxt = w_count_inc;
                    w_out_nxt   = (w_count_inc >= w_lo_act);
                    if (w_wrap) begin
                        if (!i_en[k] || !w_div_ok) begin
                            w_state_nxt  = IDLE;
                            w_div_nxt    = '0;
                            w_active_nxt = 1'b0;
                            w_count_nxt  = '0;
                            w_out_nxt    = 1'b0;
                        end else begin
                            w_div_nxt = w_div_in;
                        end
                    end
`ifdef CLK_DOWN_SYNC_EN
                    if (i_sync) begin
                        w_count_nxt = '0;
                        w_out_nxt   = 1'b0;
                        if (w_div_ok) begin
                            w_state_nxt  = RUN;
                            w_div_nxt    = w_div_in;
                            w_active_nxt = 1'b1;
                        end else begin
                            w_state_nxt  = IDLE;
                            w_div_nxt    = '0;
                            w_active_nxt = 1'b0;
                        end
                    end
`endif
                end
                default: begin
                    w_state_nxt  = IDLE;
                    w_count_nxt  = '0;
                    w_div_nxt    = '0;
                    w_out_nxt    = 1'b0;
                    w_active_nxt = 1'b0;
                end
            endcase
        end

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_state   <= IDLE;
                r_count   <= '0;
                r_div_act <= '0;
                r_out     <= 1'b0;
                r_tick    <= 1'b0;
                r_active  <= 1'b0;
            end else begin
                r_state   <= w_state_nxt;
                r_count   <= w_count_nxt;
                r_div_act <= w_div_nxt;
                r_out     <= w_out_nxt;
                r_tick    <= ~r_out & w_out_nxt;
                r_active  <= w_active_nxt;
            end
        end

        assign o_slow_clk[k] = r_out;
        assign o_tick[k]     = r_tick;
        assign o_active[k]   = r_active;
    end

endmodule

// File: tb/tb_clock_down_multi.sv
// Directed testbench for clock_down_multi: vector table plus hand-written multi-cycle sequences.
module tb_clock_down_multi;
    localparam int NCH   = 2;
    localparam int DIV_W = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NCH*DIV_W-1:0] div;
    logic [NCH-1:0]       en;
    logic                 sync;
    logic [NCH-1:0]       slow;
    logic [NCH-1:0]       tick;
    logic [NCH-1:0]       act;

    always #5 clk = ~clk;

    clock_down_multi #(.NCH(NCH), .DIV_W(DIV_W)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_divisor  (div),
        .i_en       (en),
`ifdef CLK_DOWN_SYNC_EN
        .i_sync     (sync),
`endif
        .o_slow_clk (slow),
        .o_tick     (tick),
        .o_active   (act)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, a, e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic       rst;
        logic [1:0] en;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [1:0] slow;
        logic [1:0] tick;
        logic [1:0] act;
    } vec_t;

    localparam int NV = 17;
    vec_t tbl [NV];

    initial begin
        logic exp_out;
        logic prev_out;

        tbl = '{
            '{1'b0, 2'b11, 16'd4, 16'd5, 2'b00, 2'b00, 2'b11},
            '{1'b0, 2'b11, 16'd4, 16'd5, 2'b01, 2'b01, 2'b11},
            '{1'b0, 2'b11, 16'd4, 16'd5, 2'b11, 2'b10, 2'b11},
            '{1'b0, 2'b11, 16'd4, 16'd5, 2'b10, 2'b00, 2'b11},
            '{1'b0, 2'b11, 16'd4, 16'd5, 2'b00, 2'b00, 2'b11},
            '{1'b0, 2'b11, 16'd4, 16'd5, 2'b01, 2'b01, 2'b11},
            '{1'b0, 2'b11, 16'd4, 16'd5, 2'b01, 2'b00, 2'b11},
            '{1'b0, 2'b11, 16'd4, 16'd5, 2'b10, 2'b10, 2'b11},
            '{1'b0, 2'b11, 16'd4, 16'd5, 2'b10, 2'b00, 2'b11},
            '{1'b0, 2'b11, 16'd4, 16'd5, 2'b01, 2'b01, 2'b11},
            '{1'b1, 2'b11, 16'd2, 16'd3, 2'b00, 2'b00, 2'b00},
            '{1'b0, 2'b11, 16'd2, 16'd3, 2'b01, 2'b01, 2'b11},
            '{1'b0, 2'b11, 16'd2, 16'd3, 2'b10, 2'b10, 2'b11},
            '{1'b0, 2'b11, 16'd2, 16'd3, 2'b01, 2'b01, 2'b11},
            '{1'b0, 2'b11, 16'd2, 16'd3, 2'b00, 2'b00, 2'b11},
            '{1'b0, 2'b11, 16'd2, 16'd3, 2'b11, 2'b11, 2'b11},
            '{1'b0, 2'b11, 16'd2, 16'd3, 2'b00, 2'b00, 2'b11}
        };

        // Reset held with channels requesting to run
        rst  = 1'b1;
        en   = 2'b11;
        div  = {16'd5, 16'd4};
        sync = 1'b0;
        for (int c = 0; c < 30; c++) begin
            step();
            chk("reset_slow", 32'(slow), 32'd0);
            chk("reset_tick", 32'(tick), 32'd0);
            chk("reset_active", 32'(act), 32'd0);
        end

        // Vector table: div 4/5 waveform, then div 2/3 after a reset row
        for (int i = 0; i < NV; i++) begin
            rst = tbl[i].rst;
            en  = tbl[i].en;
            div = {tbl[i].d1, tbl[i].d0};
            step();
            chk($sformatf("vec%0d_slow", i), 32'(slow), 32'(tbl[i].slow));
            chk($sformatf("vec%0d_tick", i), 32'(tick), 32'(tbl[i].tick));
            chk($sformatf("vec%0d_active", i), 32'(act), 32'(tbl[i].act));
        end

        // Invalid divisors never leave IDLE
        rst = 1'b1;
        step();
        rst = 1'b0;
        en  = 2'b11;
        div = {16'd1, 16'd0};
        for (int c = 0; c < 50; c++) begin
            if (c == 25) div = {16'd0, 16'd1};
            step();
            chk("invalid_outputs", 32'({slow, tick, act}), 32'd0);
        end

        // Mid-period divisor change 100 -> 6 is deferred to the boundary
        rst = 1'b1;
        step();
        en  = 2'b01;
        div = {16'd7, 16'd100};
        rst = 1'b0;
        prev_out = 1'b0;
        for (int e = 1; e <= 105; e++) begin
            step();
            exp_out = (e <= 100) ? ((e % 100) >= 50) : (((e - 100) % 6) >= 3);
            chk($sformatf("divchg_slow_e%0d", e), 32'(slow[0]), 32'(exp_out));
            chk($sformatf("divchg_tick_e%0d", e), 32'(tick[0]), 32'(~prev_out & exp_out));
            chk($sformatf("divchg_active_e%0d", e), 32'(act), 32'b01);
            prev_out = exp_out;
            if (e == 30) div = {16'd7, 16'd6};
        end

        // Asynchronous reset in the middle of a high phase clears without a clock edge
        rst = 1'b1;
        #2;
        chk("async_rst_slow", 32'(slow), 32'd0);
        chk("async_rst_active", 32'(act), 32'd0);
        step();

        // Enable dropped during the high phase of a 101 divide
        en  = 2'b01;
        div = {16'd0, 16'd101};
        rst = 1'b0;
        for (int e = 1; e <= 130; e++) begin
            step();
            exp_out = (e <= 100) && (e >= 51);
            chk($sformatf("endrop_slow_e%0d", e), 32'(slow[0]), 32'(exp_out));
            chk($sformatf("endrop_active_e%0d", e), 32'(act[0]), 32'(e <= 100));
            if (e == 70) en = 2'b00;
        end

`ifdef CLK_DOWN_SYNC_EN
        // Realign two offset channels with a sync pulse
        rst = 1'b1;
        step();
        en  = 2'b01;
        div = {16'd6, 16'd8};
        rst = 1'b0;
        step();
        step();
        en = 2'b11;
        step();
        step();
        step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        chk("sync_slow_e0", 32'(slow), 32'b00);
        chk("sync_tick_e0", 32'(tick), 32'b00);
        chk("sync_active_e0", 32'(act), 32'b11);
        step();
        chk("sync_slow_e1", 32'(slow), 32'b00);
        step();
        chk("sync_slow_e2", 32'(slow), 32'b00);
        step();
        chk("sync_slow_e3", 32'(slow), 32'b10);
        chk("sync_tick_e3", 32'(tick), 32'b10);
        step();
        chk("sync_slow_e4", 32'(slow), 32'b11);
        chk("sync_tick_e4", 32'(tick), 32'b01);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
